// File: rtl/mdc_pkg.sv
// Shared types and constants for the multi_dataflow reconfiguration front-end.
package mdc_pkg;

  localparam int DATA_W = 32;
  localparam int ID_W   = 8;

  localparam logic [ID_W-1:0] CFG_IDLE = 8'd0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    SWITCH = 3'd3,
    SETTLE = 3'd4
  } state_t;

endpackage

// File: rtl/mdc_quiet_timer.sv
// Saturating cycle counter: held at zero while disabled or on activity, done on the
// last cycle of a LIMIT-long quiet run.
module mdc_quiet_timer #(
  parameter  int LIMIT = 16,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic en,
  input  logic act,
  output logic done
);

  logic [CNT_W-1:0] cnt_r;

  // Count quiet enabled cycles, saturating at LIMIT.
  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!en || act) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r != CNT_W'(LIMIT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Activity in the final cycle restarts the run rather than completing it.
  always_comb begin
    done = 1'b0;
    if (en && !act && (cnt_r == CNT_W'(LIMIT - 1))) begin
      done = 1'b1;
    end else begin
      done = 1'b0;
    end
  end

endmodule

// File: rtl/mdc_reconfig_ctrl.sv
// Front-end of multi_dataflow: gates the two host streams and changes ID only after
// the datapath outputs have gone quiet.
module mdc_reconfig_ctrl #(
  parameter int DATA_W     = mdc_pkg::DATA_W,
  parameter int ID_W       = mdc_pkg::ID_W,
  parameter int NUM_CFG    = 2,
  parameter int QUIET_CYC  = 16,
  parameter int MAX_DRAIN  = 4096,
  parameter int SETTLE_CYC = 4
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [ID_W-1:0]   cfg_id,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_write,
  output logic              s0_full_n,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_write,
  output logic              s1_full_n,
  output logic [DATA_W-1:0] in0_data,
  output logic              in0_write,
  input  logic              in0_full_n,
  output logic [DATA_W-1:0] in1_data,
  output logic              in1_write,
  input  logic              in1_full_n,
  input  logic              out0_write,
  input  logic              out1_write,
  output logic [ID_W-1:0]   ID,
  output logic              busy,
  output logic              err_cfg,
  output logic              err_timeout
);

  import mdc_pkg::*;

  state_t          state_r, state_n;
  logic [ID_W-1:0] id_r, id_n, pend_r, pend_n;
  logic            gate_r, cfg_ready_r, busy_r, err_cfg_r, err_timeout_r;
  logic            accept_s, legal_s, err_cfg_s, timeout_s;
  logic            quiet_done_s, drain_done_s, settle_done_s;

  mdc_quiet_timer #(.LIMIT(QUIET_CYC)) u_quiet (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .en(state_r == DRAIN), .act(out0_write | out1_write), .done(quiet_done_s)
  );

  mdc_quiet_timer #(.LIMIT(MAX_DRAIN)) u_drain (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .en(state_r == DRAIN), .act(1'b0), .done(drain_done_s)
  );

  mdc_quiet_timer #(.LIMIT(SETTLE_CYC)) u_settle (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .en(state_r == SETTLE), .act(1'b0), .done(settle_done_s)
  );

  // Next-state, ID/pending updates and error strobes.
  always_comb begin
    accept_s  = cfg_valid & cfg_ready_r;
    legal_s   = (cfg_id <= ID_W'(NUM_CFG));
    state_n   = state_r;
    id_n      = id_r;
    pend_n    = pend_r;
    err_cfg_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && !legal_s) begin
          err_cfg_s = 1'b1;
        end else if (accept_s && (cfg_id != CFG_IDLE)) begin
          id_n    = cfg_id;
          state_n = SETTLE;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (accept_s && !legal_s) begin
          err_cfg_s = 1'b1;
        end else if (accept_s && (cfg_id != id_r)) begin
          pend_n  = cfg_id;
          state_n = DRAIN;
        end else begin
          state_n = RUN;
        end
      end
      DRAIN: begin
        // ID is loaded on the edge into SWITCH so it is stable for the whole SWITCH cycle.
        if (quiet_done_s) begin
          id_n    = pend_r;
          state_n = SWITCH;
        end else if (drain_done_s) begin
          timeout_s = 1'b1;
          id_n      = pend_r;
          state_n   = SWITCH;
        end else begin
          state_n = DRAIN;
        end
      end
      SWITCH: begin
        if (pend_r == CFG_IDLE) begin
          state_n = IDLE;
        end else begin
          state_n = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_done_s) begin
          state_n = RUN;
        end else begin
          state_n = SETTLE;
        end
      end
      default: begin
        state_n = IDLE;
        id_n    = CFG_IDLE;
      end
    endcase
  end

  // State and registered status outputs; gate opens only once RUN is stable.
  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      state_r       <= IDLE;
      id_r          <= CFG_IDLE;
      pend_r        <= CFG_IDLE;
      gate_r        <= 1'b0;
      cfg_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
      err_cfg_r     <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      id_r          <= id_n;
      pend_r        <= pend_n;
      gate_r        <= (state_r == RUN) && (state_n == RUN);
      cfg_ready_r   <= (state_n == IDLE) || (state_n == RUN);
      busy_r        <= (state_n == DRAIN) || (state_n == SWITCH) || (state_n == SETTLE);
      err_cfg_r     <= err_cfg_s;
      err_timeout_r <= err_timeout_r | timeout_s;
    end
  end

  assign in0_data    = s0_data;
  assign in1_data    = s1_data;
  assign in0_write   = s0_write & gate_r;
  assign in1_write   = s1_write & gate_r;
  assign s0_full_n   = in0_full_n & gate_r;
  assign s1_full_n   = in1_full_n & gate_r;
  assign ID          = id_r;
  assign cfg_ready   = cfg_ready_r;
  assign busy        = busy_r;
  assign err_cfg     = err_cfg_r;
  assign err_timeout = err_timeout_r;

endmodule
